tm1638_responder: RTL



---
 rtl/tm1638_responder_pkg.sv | 36 +++
 rtl/tm1638_sync_edge.sv | 26 ++
 rtl/tm1638_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tm1638_responder_pkg.sv
// Shared TM1638 command encodings, responder FSM states and key-scan bit mapping.
package tm1638_responder_pkg;

    // Command class in bits 7:6 of the first byte of a frame
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Data-command bit indices
    localparam int DC_READ  = 1;
    localparam int DC_FIXED = 2;

    // Display-control field indices
    localparam int DISP_ON_BIT = 3;
    localparam int BRIGHT_MSB  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA_WR,
        ST_KEY_RD,
        ST_IGNORE
    } state_t;

    // Serial key-scan bit idx: byte n carries key n in bit 0 and key n+4 in bit 4
    function automatic logic key_bit(input logic [7:0] kl, input logic [31:0] idx);
        logic [31:0] n;
        n = idx >> 3;
        key_bit = 1'b0;
        if (idx[2:0] == 3'd0 && n < 32'd8)
            key_bit = kl[n[2:0]];
        else if (idx[2:0] == 3'd4 && n < 32'd4)
            key_bit = kl[n[2:0] + 3'd4];
    endfunction

endpackage

// File: rtl/tm1638_sync_edge.sv
// Multi-flop synchroniser with rise/fall detection on the synchronised level.
module tm1638_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RESET_,
    input  logic din,
    output logic rise,
    output logic fall
);

    // pipe[STAGES-1] is the synchronised level, pipe[STAGES] its previous value
    logic [STAGES:0] pipe;

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_)
            pipe <= {(STAGES+1){RST_VAL}};
        else
            pipe <= {pipe[STAGES-1:0], din};
    end

    assign rise =  pipe[STAGES-1] & ~pipe[STAGES];
    assign fall = ~pipe[STAGES-1] &  pipe[STAGES];

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side emulation: decodes master frames, holds the 16-byte display
// RAM and display control, and serialises the key bitmap on read commands.
module tm1638_responder
    import tm1638_responder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int KEY_BYTES   = 4
) (
    input  logic         CLK,
    input  logic         RESET_,
    input  logic         stb_in,
    input  logic         clk_in,
    input  logic         dio_in,
    output logic         dio_out,
    output logic         dio_oe,
    input  logic [7:0]   keys,
    output logic [127:0] disp_ram,
    output logic [7:0]   leds,
    output logic         display_on,
    output logic [2:0]   brightness,
    output logic         frame_done,
    output logic         cmd_err
);

    localparam int RD_BITS = 8 * KEY_BYTES;
    localparam int RCW     = $clog2(RD_BITS + 1);

    logic stb_rise, stb_fall, clk_rise, clk_fall;
    logic [SYNC_STAGES-1:0] dio_pipe;
    logic dio_s;

    tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_stb_sync (
        .CLK    (CLK),
        .RESET_ (RESET_),
        .din    (stb_in),
        .rise   (stb_rise),
        .fall   (stb_fall)
    );

    tm1638_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk_sync (
        .CLK    (CLK),
        .RESET_ (RESET_),
        .din    (clk_in),
        .rise   (clk_rise),
        .fall   (clk_fall)
    );

    // DIO needs no edge detect; same depth keeps it aligned with the CLK edges
    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_)
            dio_pipe <= '1;
        else
            dio_pipe <= {dio_pipe[SYNC_STAGES-2:0], dio_in};
    end
    assign dio_s = dio_pipe[SYNC_STAGES-1];

    state_t            state, state_next;
    logic [2:0]        bit_cnt;
    logic [6:0]        shreg;
    logic [7:0]        byte_full;
    logic              byte_done;
    logic              auto_inc;
    logic [3:0]        addr;
    logic [15:0][7:0]  ram;
    logic [7:0]        key_latch;
    logic [RCW-1:0]    rd_cnt;

    // LSB-first shift: the 8th bit lands on top of the seven already collected
    assign byte_full = {dio_s, shreg};

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // STB rise dominates everything, so a byte completing in that cycle is dropped
    always_comb begin
        state_next = state;
        byte_done  = 1'b0;
        if (stb_rise) begin
            state_next = ST_IDLE;
        end else if (stb_fall) begin
            state_next = ST_CMD;
        end else if (clk_rise) begin
            unique case (state)
                ST_CMD: begin
                    if (bit_cnt == 3'd7) begin
                        byte_done = 1'b1;
                        case (byte_full[7:6])
                            CMD_DATA: state_next = byte_full[DC_READ] ? ST_KEY_RD : ST_IGNORE;
                            CMD_ADDR: state_next = ST_DATA_WR;
                            default:  state_next = ST_IGNORE;
                        endcase
                    end
                end
                ST_DATA_WR: begin
                    if (bit_cnt == 3'd7)
                        byte_done = 1'b1;
                end
                ST_KEY_RD: begin
                    if (rd_cnt == RCW'(RD_BITS - 1))
                        state_next = ST_IGNORE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_) begin
        if (!RESET_) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            auto_inc   <= 1'b1;
            addr       <= '0;
            ram        <= '0;
            key_latch  <= '0;
            rd_cnt     <= '0;
            display_on <= 1'b0;
            brightness <= '0;
            dio_oe     <= 1'b0;
            dio_out    <= 1'b1;
            frame_done <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            frame_done <= stb_rise;
            cmd_err    <= 1'b0;
            if (stb_rise) begin
                dio_oe  <= 1'b0;
                dio_out <= 1'b1;
            end else if (stb_fall) begin
                bit_cnt <= '0;
            end else begin
                if (clk_rise && (state == ST_CMD || state == ST_DATA_WR)) begin
                    shreg   <= byte_full[7:1];
                    bit_cnt <= bit_cnt + 3'd1;
                end

                if (byte_done && state == ST_CMD) begin
                    case (byte_full[7:6])
                        CMD_DATA: begin
                            auto_inc <= ~byte_full[DC_FIXED];
                            if (byte_full[DC_READ]) begin
                                key_latch <= keys;
                                rd_cnt    <= '0;
                            end
                        end
                        CMD_ADDR: addr <= byte_full[3:0];
                        CMD_DISP: begin
                            display_on <= byte_full[DISP_ON_BIT];
                            brightness <= byte_full[BRIGHT_MSB:0];
                        end
                        default: cmd_err <= 1'b1;
                    endcase
                end

                if (byte_done && state == ST_DATA_WR) begin
                    ram[addr] <= byte_full;
                    if (auto_inc)
                        addr <= addr + 4'd1;
                end

                // Bits are presented on CLK fall and consumed by the master on CLK rise
                if (state == ST_KEY_RD) begin
                    if (clk_fall && rd_cnt < RCW'(RD_BITS)) begin
                        dio_oe  <= 1'b1;
                        dio_out <= key_bit(key_latch, 32'(rd_cnt));
                    end
                    if (clk_rise) begin
                        rd_cnt <= rd_cnt + RCW'(1);
                        if (rd_cnt == RCW'(RD_BITS - 1)) begin
                            dio_oe  <= 1'b0;
                            dio_out <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign disp_ram = ram;

    for (genvar k = 0; k < 8; k++) begin : g_leds
        assign leds[k] = ram[2*k+1][0];
    end

endmodule
